rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Shares one single-port synchronous cartridge ROM (iNES image, header retained) between the CPU and PPU fetch paths. Each requester raises a request with an address and gets back one data byte plus a one-cycle valid strobe. The block maps CPU PRG space ($8000–$FFFF, with mirroring) and PPU CHR space ($0000–$1FFF) onto flat ROM offsets and arbitrates round-robin. It sits between the CPU/PPU bus decoders and the ROM macro, and replaces the dual-ported ROM access.

## Interface
- PRG_BANKS, 1: number of 16 KiB PRG banks; 1 (NROM-128, mirrored) or 2 (NROM-256).
- HDR_BYTES, 16: iNES header length preceding PRG in the image.
- ROM_AW, 16: ROM address width.
- clk  in  1: single system clock.
- rst_n  in  1: asynchronous, active-low reset.
- cpu_req  in  1: CPU read request; held with stable cpu_ab until cpu_valid.
- cpu_ab  in  16: CPU address.
- cpu_do  out  8: CPU read data; holds last value until next cpu_valid.
- cpu_valid  out  1: one-cycle strobe, cpu_do is valid.
- ppu_req  in  1: PPU read request; same rules as cpu_req.
- ppu_ab  in  14: PPU address.
- ppu_do  out  8: PPU read data.
- ppu_valid  out  1: one-cycle strobe for ppu_do.
- rom_en  out  1: ROM read enable.
- rom_addr  out  ROM_AW: registered ROM address.
- rom_q  in  8: ROM data, one cycle after rom_en.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req is high, grant it, load rom_addr, latch the grant id, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: rom_en=1 for the in-range case. Always go to RESP.
- RESP: register rom_q (or 8'hFF when out of range) into the granted requester's *_do, and pulse its *_valid.
  - If the other requester's req is high, grant it directly and go to ISSUE.
  - Otherwise go to IDLE.
  - The just-served requester's req is masked in RESP.
- Tie (both req high when granting): the requester not in last_grant wins. last_grant updates on every grant.
- CPU map: cpu_ab[15]=1 is in range.
  - Offset is cpu_ab[13:0] for PRG_BANKS=1 (so $8000 and $C000 mirror), or cpu_ab[14:0] for PRG_BANKS=2.
  - rom_addr = HDR_BYTES + offset.
- PPU map: ppu_ab[13]=0 is in range. rom_addr = HDR_BYTES + PRG_BANKS·16384 + ppu_ab[12:0].
- Out-of-range request: rom_en stays 0 and no ROM access occurs. The requester still gets valid, with data 8'hFF, at normal latency.
- All arithmetic is unsigned, zero-extended to ROM_AW. There is no wrap; max offset is 0xA00F with ROM_AW=16.
- Reset values: state=IDLE, last_grant=CPU (PPU wins the first tie), rom_en=0, rom_addr=0, cpu_valid=ppu_valid=0, cpu_do=ppu_do=8'h00.
- Reset mid-access: any in-flight transaction is dropped with no valid, and outputs return to their reset values immediately.
- A req dropped before valid is a protocol violation. The arbiter still completes the transaction and pulses valid.

## Timing
- req sampled high in IDLE at edge E0. Then:
  - ISSUE during cycle 1: rom_en, rom_addr.
  - RESP during cycle 2: rom_q captured at the end of cycle 2.
  - *_valid high during cycle 3.
- Request-to-valid latency is 3 cycles.
- Requester drops req, or presents a new address, in the cycle after valid. That next request is sampled one cycle later, so a single requester completes one access per 4 cycles.
- Under contention, accesses alternate every 2 cycles (RESP→ISSUE chaining). There is no idle bubble.
- *_do is registered and changes only in the cycle its valid is high.

## Structure
- Package nes_rom_pkg holds:
  - state enum {IDLE, ISSUE, RESP};
  - requester enum {REQ_CPU, REQ_PPU};
  - constants PRG_BANK_BYTES=16384, CHR_BYTES=8192, OPEN_BUS=8'hFF.
- Sub-module rom_addr_map: purely combinational. It takes the requester id, cpu_ab and ppu_ab, and produces the ROM offset and an in_range flag.
- The FSM, round-robin pointer and output registers live in rom_arbiter.

## Test plan
- PRG_BANKS=1, CPU reads $FFFC then $FFFD → rom_addr 0x400C/0x400D; cpu_do 07 then C0; valid 3 cycles after each request.
- CPU reads $C007 and $8007 → both give rom_addr 0x0017 and cpu_do 78 (mirror check).
- PPU sweeps ppu_ab 0x0000–0x003F → rom_addr = ppu_ab+0x4010; ppu_do matches the image file.
- After reset, cpu_req and ppu_req rise in the same cycle → PPU is served first (valid at +3), then CPU (valid at +5). With both held, grants alternate.
- CPU reads $2002 and PPU reads $2400 → rom_en stays 0; data FF; valid at +3.
- rst_n asserted during ISSUE → no valid ever pulses for that request; all outputs read zero. After release, a new request completes normally.

Source files
------------

// File: rtl/nes_rom_pkg.sv
// nes_rom_pkg: shared types and constants for the cartridge ROM arbiter.
package nes_rom_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   typedef enum logic {REQ_CPU, REQ_PPU} req_t;
   localparam int PRG_BANK_BYTES = 16384;
   localparam int CHR_BYTES = 8192;
   localparam logic [7:0] OPEN_BUS = 8'hFF;
endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: CPU/PPU request ports and ROM macro port of the arbiter.
interface rom_arbiter_if #(parameter int ROM_AW = 16);
   logic              cpu_req;
   logic [15:0]       cpu_ab;
   logic [7:0]        cpu_do;
   logic              cpu_valid;
   logic              ppu_req;
   logic [13:0]       ppu_ab;
   logic [7:0]        ppu_do;
   logic              ppu_valid;
   logic              rom_en;
   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]        rom_q;
   modport slave (
      input  cpu_req, cpu_ab, ppu_req, ppu_ab, rom_q,
      output cpu_do, cpu_valid, ppu_do, ppu_valid, rom_en, rom_addr
   );
   modport master (
      output cpu_req, cpu_ab, ppu_req, ppu_ab, rom_q,
      input  cpu_do, cpu_valid, ppu_do, ppu_valid, rom_en, rom_addr
   );
endinterface

// File: rtl/rom_addr_map.sv
// rom_addr_map: maps CPU PRG / PPU CHR addresses onto flat iNES image offsets.
module rom_addr_map import nes_rom_pkg::*; #(
   parameter int PRG_BANKS = 1,
   parameter int HDR_BYTES = 16,
   parameter int ROM_AW    = 16
) (
   input  req_t              i_id,
   input  logic [15:0]       i_cpu_ab,
   input  logic [13:0]       i_ppu_ab,
   output logic [ROM_AW-1:0] o_addr,
   output logic              o_in_range
);
   logic [14:0]       w_prg_off;
   logic [ROM_AW-1:0] w_cpu_addr;
   logic [ROM_AW-1:0] w_ppu_addr;
   always_comb begin
      // a single 16 KiB bank drops A14 so $8000 and $C000 alias
      w_prg_off  = PRG_BANKS == 2 ? i_cpu_ab[14:0] : {1'b0, i_cpu_ab[13:0]};
      w_cpu_addr = ROM_AW'(HDR_BYTES) + ROM_AW'(w_prg_off);
      w_ppu_addr = ROM_AW'(HDR_BYTES + PRG_BANKS * PRG_BANK_BYTES)
                 + ROM_AW'(i_ppu_ab & 14'(CHR_BYTES - 1));
      o_addr     = i_id == REQ_PPU ? w_ppu_addr : w_cpu_addr;
      o_in_range = i_id == REQ_PPU ? !i_ppu_ab[13] : i_cpu_ab[15];
   end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one synchronous cartridge ROM between CPU and PPU.
module rom_arbiter import nes_rom_pkg::*; #(
   parameter int PRG_BANKS = 1,
   parameter int HDR_BYTES = 16,
   parameter int ROM_AW    = 16
) (
   input logic          clk,
   input logic          rst_n,
   rom_arbiter_if.slave bus
);
   state_t            r_state, w_next;
   req_t              r_gnt, w_gnt;
   logic              r_rng, r_rom_en, r_cpu_valid, r_ppu_valid;
   logic              w_cpu_req, w_ppu_req, w_take, w_rng;
   logic [ROM_AW-1:0] r_rom_addr, w_addr;
   logic [7:0]        r_cpu_do, r_ppu_do, w_data;

   rom_addr_map #(.PRG_BANKS(PRG_BANKS), .HDR_BYTES(HDR_BYTES), .ROM_AW(ROM_AW)) u_map (
      .i_id      (w_gnt),
      .i_cpu_ab  (bus.cpu_ab),
      .i_ppu_ab  (bus.ppu_ab),
      .o_addr    (w_addr),
      .o_in_range(w_rng)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;

   // a just-served requester is ignored in RESP and in its valid cycle, since its req is still up
   always_comb begin
      w_cpu_req = bus.cpu_req && !r_cpu_valid && !(r_state == RESP && r_gnt == REQ_CPU);
      w_ppu_req = bus.ppu_req && !r_ppu_valid && !(r_state == RESP && r_gnt == REQ_PPU);
      w_gnt     = (w_cpu_req && w_ppu_req) ? (r_gnt == REQ_CPU ? REQ_PPU : REQ_CPU)
                                           : (w_ppu_req ? REQ_PPU : REQ_CPU);
      w_take    = r_state != ISSUE && (w_cpu_req || w_ppu_req);
      w_next    = r_state == ISSUE ? RESP : (w_take ? ISSUE : IDLE);
      w_data    = r_rng ? bus.rom_q : OPEN_BUS;
   end

   // r_gnt doubles as last_grant: it is rewritten on every grant
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_gnt       <= REQ_CPU;
         r_rng       <= 1'b0;
         r_rom_en    <= 1'b0;
         r_rom_addr  <= '0;
         r_cpu_valid <= 1'b0;
         r_ppu_valid <= 1'b0;
         r_cpu_do    <= 8'h00;
         r_ppu_do    <= 8'h00;
      end else begin
         r_rom_en    <= w_take && w_rng;
         r_cpu_valid <= r_state == RESP && r_gnt == REQ_CPU;
         r_ppu_valid <= r_state == RESP && r_gnt == REQ_PPU;
         if (w_take) begin
            r_gnt      <= w_gnt;
            r_rng      <= w_rng;
            r_rom_addr <= w_addr;
         end
         if (r_state == RESP && r_gnt == REQ_CPU) r_cpu_do <= w_data;
         if (r_state == RESP && r_gnt == REQ_PPU) r_ppu_do <= w_data;
      end

   assign bus.rom_en    = r_rom_en;
   assign bus.rom_addr  = r_rom_addr;
   assign bus.cpu_valid = r_cpu_valid;
   assign bus.ppu_valid = r_ppu_valid;
   assign bus.cpu_do    = r_cpu_do;
   assign bus.ppu_do    = r_ppu_do;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed checks of mapping, latency, round-robin and reset of rom_arbiter.
module tb_rom_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] mem [0:65535];

   always #5 clk = ~clk;

   rom_arbiter_if #(.ROM_AW(16)) bus ();
   rom_arbiter #(.PRG_BANKS(1), .HDR_BYTES(16), .ROM_AW(16)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always @(posedge clk) if (bus.rom_en) bus.rom_q <= mem[bus.rom_addr];

   function automatic logic [7:0] img(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // raise a request, observe the ISSUE cycle, wait for valid, then one more cycle with req still up
   task automatic access(input bit ppu, input logic [15:0] ab, output logic en, output logic [15:0] addr,
                         output int lat, output logic [7:0] d, output logic v_after);
      if (ppu) begin bus.ppu_req = 1'b1; bus.ppu_ab = ab[13:0]; end
      else begin bus.cpu_req = 1'b1; bus.cpu_ab = ab; end
      lat = -1; d = 8'h00; en = 1'b0; addr = 16'h0;
      for (int i = 1; i <= 8 && lat < 0; i++) begin
         tick;
         if (i == 1) begin en = bus.rom_en; addr = bus.rom_addr; end
         if (ppu ? bus.ppu_valid : bus.cpu_valid) begin lat = i; d = ppu ? bus.ppu_do : bus.cpu_do; end
      end
      tick;
      v_after = ppu ? bus.ppu_valid : bus.cpu_valid;
   endtask

   task automatic test_reset;
      logic [41:0] obs;
      tick; tick;
      obs = {bus.rom_en, bus.cpu_valid, bus.ppu_valid, bus.rom_addr, bus.cpu_do, bus.ppu_do};
      checks++;
      if (obs !== 42'h0) begin errors++; $display("FAIL reset_outputs got %h exp 0", obs); end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_contention;
      logic [1:0] exp_v, got_v;
      bus.cpu_ab = 16'hFFFC; bus.ppu_ab = 14'h0005;
      bus.cpu_req = 1'b1; bus.ppu_req = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick;
         exp_v = {i == 5 || i == 9, i == 3 || i == 7};
         got_v = {bus.cpu_valid, bus.ppu_valid};
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL contention_valid cyc %0d got %b exp %b", i, got_v, exp_v); end
         if (i == 1) begin
            checks++;
            if ({bus.rom_en, bus.rom_addr} !== {1'b1, 16'h4015}) begin
               errors++; $display("FAIL contention_first_ppu got en %b addr %h exp 1 4015", bus.rom_en, bus.rom_addr);
            end
         end
         if (i == 3) begin
            checks++;
            if ({bus.rom_en, bus.rom_addr} !== {1'b1, 16'h400C}) begin
               errors++; $display("FAIL contention_chain_cpu got en %b addr %h exp 1 400c", bus.rom_en, bus.rom_addr);
            end
            checks++;
            if (bus.ppu_do !== img(16'h4015)) begin errors++; $display("FAIL contention_ppu_do got %h exp %h", bus.ppu_do, img(16'h4015)); end
         end
         if (i == 5) begin
            checks++;
            if (bus.cpu_do !== 8'h07) begin errors++; $display("FAIL contention_cpu_do got %h exp 07", bus.cpu_do); end
         end
      end
      bus.cpu_req = 1'b0; bus.ppu_req = 1'b0;
      repeat (6) tick;
   endtask

   task automatic test_prg;
      logic [15:0] ab [4]  = '{16'hFFFC, 16'hFFFD, 16'hC007, 16'h8007};
      logic [15:0] ea [4]  = '{16'h400C, 16'h400D, 16'h0017, 16'h0017};
      logic [7:0]  ed [4]  = '{8'h07, 8'hC0, 8'h78, 8'h78};
      logic en, va; logic [15:0] addr; int lat; logic [7:0] d;
      for (int k = 0; k < 4; k++) begin
         access(1'b0, ab[k], en, addr, lat, d, va);
         checks++;
         if ({en, addr} !== {1'b1, ea[k]}) begin errors++; $display("FAIL prg_addr %h got en %b addr %h exp 1 %h", ab[k], en, addr, ea[k]); end
         checks++;
         if (lat !== 3) begin errors++; $display("FAIL prg_latency %h got %0d exp 3", ab[k], lat); end
         checks++;
         if (d !== ed[k]) begin errors++; $display("FAIL prg_data %h got %h exp %h", ab[k], d, ed[k]); end
         checks++;
         if (va !== 1'b0) begin errors++; $display("FAIL prg_valid_pulse %h got %b exp 0", ab[k], va); end
      end
      bus.cpu_req = 1'b0;
      tick;
   endtask

   task automatic test_chr_sweep;
      logic en, va; logic [15:0] addr; int lat; logic [7:0] d;
      for (int a = 0; a < 64; a++) begin
         access(1'b1, 16'(a), en, addr, lat, d, va);
         checks++;
         if ({en, addr} !== {1'b1, 16'(a) + 16'h4010}) begin
            errors++; $display("FAIL chr_addr %h got en %b addr %h exp 1 %h", a, en, addr, 16'(a) + 16'h4010);
         end
         checks++;
         if ({lat == 3, d} !== {1'b1, img(16'(a) + 16'h4010)}) begin
            errors++; $display("FAIL chr_data %h got lat %0d data %h exp lat 3 data %h", a, lat, d, img(16'(a) + 16'h4010));
         end
      end
      bus.ppu_req = 1'b0;
      tick;
   endtask

   task automatic test_out_of_range;
      logic en, va; logic [15:0] addr; int lat; logic [7:0] d;
      for (int p = 0; p < 2; p++) begin
         access(p[0], p[0] ? 16'h2400 : 16'h2002, en, addr, lat, d, va);
         checks++;
         if (en !== 1'b0) begin errors++; $display("FAIL oor_rom_en req %0d got %b exp 0", p, en); end
         checks++;
         if (lat !== 3) begin errors++; $display("FAIL oor_latency req %0d got %0d exp 3", p, lat); end
         checks++;
         if (d !== 8'hFF) begin errors++; $display("FAIL oor_data req %0d got %h exp ff", p, d); end
         bus.cpu_req = 1'b0; bus.ppu_req = 1'b0;
         tick;
      end
   endtask

   task automatic test_reset_mid;
      logic [41:0] obs;
      logic en, va; logic [15:0] addr; int lat; logic [7:0] d;
      bus.cpu_req = 1'b1; bus.cpu_ab = 16'hFFFC;
      tick;
      checks++;
      if (bus.rom_en !== 1'b1) begin errors++; $display("FAIL midrst_issue got %b exp 1", bus.rom_en); end
      rst_n = 1'b0; bus.cpu_req = 1'b0;
      #1;
      obs = {bus.rom_en, bus.cpu_valid, bus.ppu_valid, bus.rom_addr, bus.cpu_do, bus.ppu_do};
      checks++;
      if (obs !== 42'h0) begin errors++; $display("FAIL midrst_outputs got %h exp 0", obs); end
      tick; tick;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++;
         if ({bus.cpu_valid, bus.ppu_valid} !== 2'b00) begin errors++; $display("FAIL midrst_no_valid cyc %0d got %b%b exp 00", i, bus.cpu_valid, bus.ppu_valid); end
      end
      access(1'b0, 16'hFFFD, en, addr, lat, d, va);
      checks++;
      if ({en, addr, lat == 3, d} !== {1'b1, 16'h400D, 1'b1, 8'hC0}) begin
         errors++; $display("FAIL midrst_recover got en %b addr %h lat %0d data %h exp 1 400d 3 c0", en, addr, lat, d);
      end
      bus.cpu_req = 1'b0;
      tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = img(16'(i));
      mem[16'h400C] = 8'h07;
      mem[16'h400D] = 8'hC0;
      mem[16'h0017] = 8'h78;
      bus.cpu_req = 1'b0; bus.cpu_ab = 16'h0;
      bus.ppu_req = 1'b0; bus.ppu_ab = 14'h0;
      test_reset;
      test_contention;
      test_prg;
      test_chr_sweep;
      test_out_of_range;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
